// File: rtl/ppu_vram_responder_if.sv
// CPU-side ($2007-style) VRAM access port of the PPU VRAM responder.
interface ppu_vram_responder_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;

   modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, input cpu_ack, cpu_rdata);
   modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_wdata, output cpu_ack, cpu_rdata);
endinterface

// File: rtl/ppu_vram_responder.sv
// PPU VRAM responder: zero-latency renderer reads plus an arbitrated CPU port over CHR/nametable/palette space.
// Optional PPU_READ_BUFFER_EN macro enables the delayed CPU read buffer.
module ppu_vram_responder #(
   parameter int unsigned NT_BYTES    = 2048,
   parameter int unsigned PAL_ENTRIES = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 render_en,
   input  logic [15:0]          render_addr,
   output logic [7:0]           render_data,
   input  logic                 mirror_vert,
   ppu_vram_responder_if.slave  cpu,
   output logic [12:0]          chr_addr,
   output logic                 chr_we,
   output logic [7:0]           chr_wdata,
   input  logic [7:0]           chr_data
);
   localparam int unsigned NT_AW  = $clog2(NT_BYTES);
   localparam int unsigned PAL_AW = $clog2(PAL_ENTRIES);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;

   function automatic logic [NT_AW-1:0] nt_index(input logic [13:0] a, input logic mv);
      return NT_AW'({mv ? a[10] : a[11], a[9:0]});
   endfunction

   // Sprite-backdrop entries 0x10/14/18/1C fold onto the background ones.
   function automatic logic [PAL_AW-1:0] pal_index(input logic [13:0] a);
      logic [4:0] idx;
      idx = a[4:0];
      if (idx[1:0] == 2'b00) idx[4] = 1'b0;
      return PAL_AW'(idx);
   endfunction

   logic [1:0]  state, state_nxt;
   logic        take;
   logic [13:0] addr_q;
   logic        we_q;
   logic [7:0]  wdata_q;
   logic        ack_q;
   logic [7:0]  rdata_q;
   logic        chr_we_q;
   logic [7:0]  chr_wdata_q;
   logic [13:0] sel_addr;
   logic        sel_is_pal;
   logic [7:0]  sel_data;
   logic        chr_take;
   logic        rd_done, wr_done;
   logic        unused_render_hi;

   logic [7:0]  nt_ram  [NT_BYTES];
   logic [5:0]  pal_ram [PAL_ENTRIES];

   assign unused_render_hi = ^render_addr[15:14];

   assign sel_addr   = (state == ST_ACCESS) ? addr_q : render_addr[13:0];
   assign sel_is_pal = (sel_addr[13:8] == 6'h3F);
   assign chr_addr   = sel_addr[12:0];

   // Asynchronous-read decode shared by the renderer and the CPU port.
   always_comb begin
      sel_data = 8'h00;
      if (!sel_addr[13])   sel_data = chr_data;
      else if (sel_is_pal) sel_data = {2'b00, pal_ram[pal_index(sel_addr)]};
      else                 sel_data = nt_ram[nt_index(sel_addr, mirror_vert)];
   end

   assign render_data = sel_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cpu.cpu_req && !render_en) begin
               take      = 1'b1;
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: state_nxt = ST_ACK;
         ST_ACK:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign chr_take = take && cpu.cpu_we && !cpu.cpu_addr[13];
   assign rd_done  = (state == ST_ACCESS) && !we_q;
   assign wr_done  = (state == ST_ACCESS) && we_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= 14'h0000;
         we_q        <= 1'b0;
         wdata_q     <= 8'h00;
         ack_q       <= 1'b0;
         chr_we_q    <= 1'b0;
         chr_wdata_q <= 8'h00;
      end else begin
         ack_q       <= (state == ST_ACCESS);
         chr_we_q    <= chr_take;
         chr_wdata_q <= chr_take ? cpu.cpu_wdata : 8'h00;
         if (take) begin
            addr_q  <= cpu.cpu_addr;
            we_q    <= cpu.cpu_we;
            wdata_q <= cpu.cpu_wdata;
         end
      end
   end

`ifdef PPU_READ_BUFFER_EN
   logic [7:0]  rbuf_q;
   logic [13:0] shadow_addr;

   // Palette reads refill the buffer from the nametable byte underneath.
   assign shadow_addr = sel_addr - 14'h1000;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= 8'h00;
         rbuf_q  <= 8'h00;
      end else if (rd_done) begin
         if (sel_is_pal) begin
            rdata_q <= sel_data;
            rbuf_q  <= nt_ram[nt_index(shadow_addr, mirror_vert)];
         end else begin
            rdata_q <= rbuf_q;
            rbuf_q  <= sel_data;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     rdata_q <= 8'h00;
      else if (rd_done) rdata_q <= sel_data;
   end
`endif

   // RAM contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_done && addr_q[13] && (addr_q[13:8] != 6'h3F))
         nt_ram[nt_index(addr_q, mirror_vert)] <= wdata_q;
      if (wr_done && (addr_q[13:8] == 6'h3F))
         pal_ram[pal_index(addr_q)] <= wdata_q[5:0];
   end

   assign cpu.cpu_ack   = ack_q;
   assign cpu.cpu_rdata = rdata_q;
   assign chr_we        = chr_we_q;
   assign chr_wdata     = chr_wdata_q;

endmodule

// File: tb/tb_ppu_vram_responder.sv
// Directed, table-driven bench for ppu_vram_responder (mirroring, palette alias, CHR port, arbitration, reset, read buffer).
module tb_ppu_vram_responder;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        render_en = 1'b0;
   logic [15:0] render_addr = 16'h0000;
   logic [7:0]  render_data;
   logic        mirror_vert = 1'b1;
   logic [12:0] chr_addr;
   logic        chr_we;
   logic [7:0]  chr_wdata;
   logic [7:0]  chr_data;

   ppu_vram_responder_if cpu_if ();

   ppu_vram_responder dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .render_en   (render_en),
      .render_addr (render_addr),
      .render_data (render_data),
      .mirror_vert (mirror_vert),
      .cpu         (cpu_if.slave),
      .chr_addr    (chr_addr),
      .chr_we      (chr_we),
      .chr_wdata   (chr_wdata),
      .chr_data    (chr_data)
   );

   always #5 clk = ~clk;

   // CHR ROM model: byte = low address byte xor 0x5C.
   assign chr_data = chr_addr[7:0] ^ 8'h5C;

`ifdef PPU_READ_BUFFER_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   int total  = 0;
   int passed = 0;

   typedef struct {
      bit          is_write;
      logic        mv;
      logic [15:0] addr;
      logic [7:0]  data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input bit w, input logic mv, input logic [15:0] a, input logic [7:0] d);
      vec_t v;
      v.is_write = w; v.mv = mv; v.addr = a; v.data = d;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic rchk(input string name, input logic mv, input logic [15:0] a, input logic [7:0] exp);
      @(negedge clk);
      mirror_vert = mv;
      render_addr = a;
      #1;
      chk(name, 16'(render_data), 16'(exp));
   endtask

   // One CPU access; lat = posedge index (sampling edge = 1) at which ack is first seen.
   task automatic cpu_access(input string name, input logic we, input logic [13:0] a, input logic [7:0] wd,
                             output logic [7:0] rd, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = -1;
      rd   = 8'h00;
      @(negedge clk);
      cpu_if.cpu_req   = 1'b1;
      cpu_if.cpu_we    = we;
      cpu_if.cpu_addr  = a;
      cpu_if.cpu_wdata = wd;
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(posedge clk); #1;
         if (cpu_if.cpu_ack) begin
            seen = 1'b1;
            lat  = n;
            rd   = cpu_if.cpu_rdata;
         end
      end
      @(negedge clk);
      cpu_if.cpu_req = 1'b0;
      if (!seen) chk({name, "_timeout"}, 16'(seen), 16'd1);
   endtask

   logic [7:0]  rd;
   int          lat;
   int          we_cnt, ack_n, ack_cnt;
   logic [12:0] we_addr;
   logic [7:0]  we_data;

   initial begin
      cpu_if.cpu_req   = 1'b0;
      cpu_if.cpu_we    = 1'b0;
      cpu_if.cpu_addr  = 14'h0000;
      cpu_if.cpu_wdata = 8'h00;

      vecs.push_back(mk(1, 1, 16'h2405, 8'h3C));
      vecs.push_back(mk(1, 1, 16'h2005, 8'hA5));
      vecs.push_back(mk(0, 1, 16'h2805, 8'hA5));
      vecs.push_back(mk(0, 1, 16'h2405, 8'h3C));
      vecs.push_back(mk(0, 1, 16'h2C05, 8'h3C));
      vecs.push_back(mk(0, 0, 16'h2405, 8'hA5));
      vecs.push_back(mk(0, 0, 16'h2C05, 8'h3C));
      vecs.push_back(mk(1, 1, 16'h3F11, 8'h15));
      vecs.push_back(mk(1, 1, 16'h3F10, 8'hFF));
      vecs.push_back(mk(0, 1, 16'h3F00, 8'h3F));
      vecs.push_back(mk(0, 1, 16'h3F11, 8'h15));
      vecs.push_back(mk(0, 1, 16'h3F10, 8'h3F));
      vecs.push_back(mk(0, 1, 16'hFF00, 8'h3F));
      vecs.push_back(mk(1, 1, 16'h3F14, 8'h2A));
      vecs.push_back(mk(0, 1, 16'h3F04, 8'h2A));
      vecs.push_back(mk(0, 1, 16'h3F24, 8'h2A));
      vecs.push_back(mk(1, 1, 16'h3F01, 8'h7E));
      vecs.push_back(mk(0, 1, 16'h3F01, 8'h3E));
      vecs.push_back(mk(1, 1, 16'h2EFF, 8'h77));
      vecs.push_back(mk(0, 1, 16'h3EFF, 8'h77));
      vecs.push_back(mk(0, 1, 16'h0123, 8'h7F));
      vecs.push_back(mk(0, 1, 16'h1FFF, 8'hA3));

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack",       16'(cpu_if.cpu_ack),   16'h0);
      chk("rst_rdata",     16'(cpu_if.cpu_rdata), 16'h0);
      chk("rst_chr_we",    16'(chr_we),           16'h0);
      chk("rst_chr_wdata", 16'(chr_wdata),        16'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Table: CPU writes (latency checked) and render-path reads.
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_write) begin
            @(negedge clk);
            mirror_vert = vecs[i].mv;
            cpu_access($sformatf("vec%0d", i), 1'b1, vecs[i].addr[13:0], vecs[i].data, rd, lat);
            chk($sformatf("vec%0d_lat", i), 16'(lat), 16'd2);
         end else begin
            rchk($sformatf("vec%0d_rd", i), vecs[i].mv, vecs[i].addr, vecs[i].data);
         end
      end

      // CHR write: one-cycle strobe with latched address/data.
      we_cnt = 0; ack_n = 0; we_addr = '0; we_data = '0;
      @(negedge clk);
      cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1;
      cpu_if.cpu_addr = 14'h1234; cpu_if.cpu_wdata = 8'h5A;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (chr_we) begin we_cnt++; we_addr = chr_addr; we_data = chr_wdata; end
         if (cpu_if.cpu_ack && ack_n == 0) begin ack_n = n; cpu_if.cpu_req = 1'b0; end
      end
      cpu_if.cpu_req = 1'b0;
      chk("chr_we_cycles", 16'(we_cnt),  16'd1);
      chk("chr_we_addr",   16'(we_addr), 16'h1234);
      chk("chr_we_data",   16'(we_data), 16'h5A);
      chk("chr_ack_lat",   16'(ack_n),   16'd2);

      // Arbitration: request blocked while the renderer owns the bus.
      cpu_access("arb_pre", 1'b1, 14'h2100, 8'h44, rd, lat);
      @(negedge clk);
      render_en = 1'b1;
      cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1;
      cpu_if.cpu_addr = 14'h2100; cpu_if.cpu_wdata = 8'h99;
      ack_cnt = 0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         if (cpu_if.cpu_ack) ack_cnt++;
      end
      chk("arb_no_ack", 16'(ack_cnt), 16'd0);
      @(negedge clk);
      render_addr = 16'h2100; #1;
      chk("arb_ram_held", 16'(render_data), 16'h44);
      @(negedge clk);
      render_en = 1'b0;
      ack_n = 0;
      for (int n = 1; n <= 10 && ack_n == 0; n++) begin
         @(posedge clk); #1;
         if (cpu_if.cpu_ack) begin ack_n = n; cpu_if.cpu_req = 1'b0; end
      end
      cpu_if.cpu_req = 1'b0;
      chk("arb_ack_lat", 16'(ack_n), 16'd2);
      rchk("arb_ram_new", 1'b1, 16'h2100, 8'h99);

      // Reset during ACCESS of a nametable write: write lost, FSM back to IDLE.
      cpu_access("rst_pre", 1'b1, 14'h2010, 8'h12, rd, lat);
      @(negedge clk);
      cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1;
      cpu_if.cpu_addr = 14'h2010; cpu_if.cpu_wdata = 8'h5E;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      cpu_if.cpu_req = 1'b0;
      ack_cnt = 0;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         if (cpu_if.cpu_ack) ack_cnt++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      if (cpu_if.cpu_ack) ack_cnt++;
      chk("rst_mid_no_ack", 16'(ack_cnt), 16'd0);
      chk("rst_mid_rdata",  16'(cpu_if.cpu_rdata), 16'h0);
      rchk("rst_mid_lost",  1'b1, 16'h2010, 8'h12);
      cpu_access("rst_after", 1'b1, 14'h2010, 8'h5E, rd, lat);
      chk("rst_after_lat", 16'(lat), 16'd2);
      rchk("rst_after_rd", 1'b1, 16'h2010, 8'h5E);

      // Reset during a CHR write drops the strobe asynchronously.
      @(negedge clk);
      cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1;
      cpu_if.cpu_addr = 14'h0040; cpu_if.cpu_wdata = 8'h33;
      @(posedge clk); #1;
      chk("rst_chr_we_on", 16'(chr_we), 16'h1);
      reset_n = 1'b0;
      #1;
      chk("rst_chr_we_off",    16'(chr_we),    16'h0);
      chk("rst_chr_wdata_off", 16'(chr_wdata), 16'h0);
      cpu_if.cpu_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // CPU reads: direct or through the delayed read buffer.
      cpu_access("buf_w0", 1'b1, 14'h2000, 8'h11, rd, lat);
      cpu_access("buf_w1", 1'b1, 14'h2001, 8'h22, rd, lat);
      cpu_access("buf_w2", 1'b1, 14'h2F00, 8'h66, rd, lat);
      cpu_access("buf_r0", 1'b0, 14'h2000, 8'h00, rd, lat);
      chk("cpu_rd_2000", 16'(rd), BUF ? 16'h00 : 16'h11);
      chk("cpu_rd_lat", 16'(lat), 16'd2);
      cpu_access("buf_r1", 1'b0, 14'h2001, 8'h00, rd, lat);
      chk("cpu_rd_2001", 16'(rd), BUF ? 16'h11 : 16'h22);
      cpu_access("buf_r2", 1'b0, 14'h3F00, 8'h00, rd, lat);
      chk("cpu_rd_3f00", 16'(rd), 16'h3F);
      cpu_access("buf_r3", 1'b0, 14'h0123, 8'h00, rd, lat);
      chk("cpu_rd_0123", 16'(rd), BUF ? 16'h66 : 16'h7F);
      cpu_access("buf_r4", 1'b0, 14'h2000, 8'h00, rd, lat);
      chk("cpu_rd_2000b", 16'(rd), BUF ? 16'h7F : 16'h11);
      repeat (2) @(posedge clk);
      #1;
      chk("cpu_rdata_held", 16'(cpu_if.cpu_rdata), BUF ? 16'h7F : 16'h11);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
